// File: rtl/stream_mux_n_if.sv
// Handshake bundle for stream_mux_n: N_IN producer channels in, one consumer out.
// MUX_PKT_LOCK_EN adds the in_last/out_last end-of-packet signals.
interface stream_mux_n_if #(
  parameter  int WIDTH = 8,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
);
  logic [N_IN-1:0][WIDTH-1:0] in_data;
  logic [N_IN-1:0]            in_valid;
  logic [N_IN-1:0]            in_ready;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_chan;
  logic                       out_valid;
  logic                       out_ready;
`ifdef MUX_PKT_LOCK_EN
  logic [N_IN-1:0]            in_last;
  logic                       out_last;
`endif

  modport master (
    output in_data, in_valid, out_ready,
`ifdef MUX_PKT_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
`ifdef MUX_PKT_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-input valid/ready stream mux, external-select or round-robin, one output register.
// Define MUX_PKT_LOCK_EN to hold round-robin grants on a channel until in_last.
module stream_mux_n_lane #(
  parameter int LANE  = 0,
  parameter int SEL_W = 2
) (
  input  logic             load,
  input  logic             gnt_vld,
  input  logic [SEL_W-1:0] gnt_idx,
  output logic             ready
);
  assign ready = load && gnt_vld && (gnt_idx == SEL_W'(LANE));
endmodule

module stream_mux_n #(
  parameter  int WIDTH = 8,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_n_if.slave    bus
);
  logic [SEL_W-1:0] last_gnt, gnt_idx, rr_idx, out_chan_q;
  logic [WIDTH-1:0] out_data_q;
  logic             gnt_vld, rr_vld, load, sel_ok, out_valid_q;
  logic [N_IN-1:0]  rdy;
`ifdef MUX_PKT_LOCK_EN
  logic             lock_vld, out_last_q;
  logic [SEL_W-1:0] lock_idx;
`endif

  assign sel_ok = int'(sel) < N_IN;
  // rst_n gating keeps every in_ready low while reset is held.
  assign load   = rst_n && (!out_valid_q || bus.out_ready);

  // Lowest offset from last_gnt+1 wins; scanning downward lets it overwrite.
  always_comb begin
    int c;
    c      = 0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = N_IN-1; i >= 0; i--) begin
      c = int'(last_gnt) + 1 + i;
      if (c >= N_IN) c = c - N_IN;
      if (bus.in_valid[SEL_W'(c)]) begin
        rr_vld = 1'b1;
        rr_idx = SEL_W'(c);
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = sel;
    if (!mode) begin
      gnt_vld = sel_ok && bus.in_valid[sel];
    end
`ifdef MUX_PKT_LOCK_EN
    else if (lock_vld) begin
      gnt_idx = lock_idx;
      gnt_vld = bus.in_valid[lock_idx];
    end
`endif
    else begin
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    stream_mux_n_lane #(.LANE(g), .SEL_W(SEL_W)) u_lane (
      .load    (load),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .ready   (rdy[g])
    );
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_gnt    <= SEL_W'(N_IN-1);
    end else if (load) begin
      if (gnt_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[gnt_idx];
        out_chan_q  <= gnt_idx;
        if (mode) last_gnt <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_PKT_LOCK_EN
  assign bus.out_last = out_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld   <= 1'b0;
      lock_idx   <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (load && gnt_vld) out_last_q <= bus.in_last[gnt_idx];
      // External select bypasses and drops any packet lock.
      if (!mode) begin
        lock_vld <= 1'b0;
      end else if (load && gnt_vld) begin
        lock_vld <= !bus.in_last[gnt_idx];
        lock_idx <= gnt_idx;
      end
    end
  end
`endif
endmodule
